// File: rtl/rf_wq_pkg.sv
// Shared types and sizing helpers for the register-file write-back queue.
package rf_wq_pkg;

  localparam int REG_W  = 5;
  localparam int DATA_W = 32;

  typedef struct packed {
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] data;
  } rf_wq_entry_t;

  // Pointer width for a power-of-two depth; never below one bit.
  function automatic int ptr_w(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/rf_wq_match.sv
// Youngest-first match of one read-port address against the pending write entries.
module rf_wq_match
  import rf_wq_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PW    = 2
) (
  input  rf_wq_entry_t [DEPTH-1:0] entries,
  input  logic [PW-1:0]            head,
  input  logic [PW:0]              count,
  input  logic [REG_W-1:0]         addr,
  output logic                     hit,
  output logic [DATA_W-1:0]        data
);

  // Walk from oldest to youngest so the last valid match (the youngest) wins.
  always_comb begin
    logic [PW-1:0] idx;
    hit  = 1'b0;
    data = '0;
    idx  = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head + PW'(k);
      if (((PW+1)'(k) < count) && (addr != '0) && (entries[idx].rd == addr)) begin
        hit  = 1'b1;
        data = entries[idx].data;
      end
    end
  end

endmodule

// File: rtl/rf_write_queue.sv
// Write-back FIFO in front of the 32x32 register file write port, with read-after-write
// resolution on both read ports. Define RF_BYPASS_EN to forward pending data instead of flagging a hazard.
module rf_write_queue
  import rf_wq_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wb_valid,
  output logic              wb_ready,
  input  logic [4:0]        wb_rd,
  input  logic [31:0]       wb_data,
  input  logic              rf_stall,
  output logic              rf_ld,
  output logic [4:0]        rf_addr,
  output logic [31:0]       rf_data,
  input  logic [4:0]        rd_a_addr,
  input  logic [4:0]        rd_b_addr,
  input  logic [31:0]       pa_in,
  input  logic [31:0]       pb_in,
  output logic [31:0]       pa_out,
  output logic [31:0]       pb_out,
  output logic              raw_hazard
);

  localparam int PW = ptr_w(DEPTH);
  localparam logic [PW:0] FULL = DEPTH[PW:0];

  rf_wq_entry_t [DEPTH-1:0] entries;
  logic [PW-1:0]            head;
  logic [PW-1:0]            tail;
  logic [PW:0]              count;
  logic                     push;
  logic                     pop;

  // Handshake: an entry transfers on a cycle with wb_valid && wb_ready; wb_ready depends
  // only on occupancy (strictly not full, even if a pop happens the same cycle).
  // Register 0 is never written, so such entries complete the handshake but are dropped.
  assign wb_ready = (count != FULL);
  assign push     = wb_valid && wb_ready && (wb_rd != '0);
  assign pop      = (count != '0) && !rf_stall;

  always_ff @(posedge clk) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  // Payload storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) entries[tail] <= {wb_rd, wb_data};
  end

  assign rf_ld   = pop;
  assign rf_addr = pop ? entries[head].rd   : '0;
  assign rf_data = pop ? entries[head].data : '0;

  logic              hit_a;
  logic              hit_b;
  logic [DATA_W-1:0] fwd_a;
  logic [DATA_W-1:0] fwd_b;

  rf_wq_match #(.DEPTH(DEPTH), .PW(PW)) u_match_a (
    .entries (entries),
    .head    (head),
    .count   (count),
    .addr    (rd_a_addr),
    .hit     (hit_a),
    .data    (fwd_a)
  );

  rf_wq_match #(.DEPTH(DEPTH), .PW(PW)) u_match_b (
    .entries (entries),
    .head    (head),
    .count   (count),
    .addr    (rd_b_addr),
    .hit     (hit_b),
    .data    (fwd_b)
  );

`ifdef RF_BYPASS_EN
  assign pa_out     = hit_a ? fwd_a : pa_in;
  assign pb_out     = hit_b ? fwd_b : pb_in;
  assign raw_hazard = 1'b0;
`else
  logic unused_fwd;
  assign unused_fwd = ^{fwd_a, fwd_b};
  assign pa_out     = pa_in;
  assign pb_out     = pb_in;
  assign raw_hazard = hit_a | hit_b;
`endif

endmodule

// File: tb/tb_rf_write_queue.sv
// Scoreboard bench for rf_write_queue: directed scenarios followed by randomized traffic.
module tb_rf_write_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_valid;
  logic        wb_ready;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        rf_stall;
  logic        rf_ld;
  logic [4:0]  rf_addr;
  logic [31:0] rf_data;
  logic [4:0]  rd_a_addr;
  logic [4:0]  rd_b_addr;
  logic [31:0] pa_in;
  logic [31:0] pb_in;
  logic [31:0] pa_out;
  logic [31:0] pb_out;
  logic        raw_hazard;

  rf_write_queue #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .wb_valid   (wb_valid),
    .wb_ready   (wb_ready),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data),
    .rf_stall   (rf_stall),
    .rf_ld      (rf_ld),
    .rf_addr    (rf_addr),
    .rf_data    (rf_data),
    .rd_a_addr  (rd_a_addr),
    .rd_b_addr  (rd_b_addr),
    .pa_in      (pa_in),
    .pb_in      (pb_in),
    .pa_out     (pa_out),
    .pb_out     (pb_out),
    .raw_hazard (raw_hazard)
  );

  // Clock / reset
  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic        mon_en = 1'b0;
  logic [36:0] exp_q[$];   // scoreboard: {rd, data} in expected drain order
  logic [36:0] pend[$];    // reference model of pending writes, oldest first
  logic [31:0] rf_model[32];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every register-file write must be the next expected one.
  always @(negedge clk) begin
    if (mon_en && rf_ld === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL drain_unexpected: got rd=%0d data=%0h expected no write", rf_addr, rf_data);
      end else begin
        logic [36:0] e;
        e = exp_q.pop_front();
        check("drain_entry", {27'd0, rf_addr, rf_data}, {27'd0, e});
      end
      rf_model[rf_addr] = rf_data;
    end
  end

  function automatic logic [32:0] model_match(input logic [4:0] addr);
    if (addr == 5'd0) return 33'd0;
    for (int i = pend.size() - 1; i >= 0; i--)
      if (pend[i][36:32] == addr) return {1'b1, pend[i][31:0]};
    return 33'd0;
  endfunction

  // Driver: one cycle of stimulus, then output checks and model update.
  task automatic step(input logic v, input logic [4:0] rd, input logic [31:0] d,
                      input logic stall, input logic rst, input logic [4:0] a, input logic [4:0] b);
    logic        exp_ready;
    logic        exp_ld;
    logic [32:0] ma;
    logic [32:0] mb;
    @(posedge clk);
    #1;
    wb_valid  = v;
    wb_rd     = rd;
    wb_data   = d;
    rf_stall  = stall;
    reset     = rst;
    rd_a_addr = a;
    rd_b_addr = b;
    pa_in     = $urandom;
    pb_in     = $urandom;
    @(negedge clk);
    #1;
    exp_ready = (pend.size() != DEPTH);
    exp_ld    = (pend.size() != 0) && !stall;
    check("wb_ready", {63'd0, wb_ready}, {63'd0, exp_ready});
    check("rf_ld", {63'd0, rf_ld}, {63'd0, exp_ld});
    if (!exp_ld) check("rf_idle_lines", {27'd0, rf_addr, rf_data}, 64'd0);
    ma = model_match(a);
    mb = model_match(b);
`ifdef RF_BYPASS_EN
    check("pa_out", {32'd0, pa_out}, {32'd0, ma[32] ? ma[31:0] : pa_in});
    check("pb_out", {32'd0, pb_out}, {32'd0, mb[32] ? mb[31:0] : pb_in});
    check("raw_hazard", {63'd0, raw_hazard}, 64'd0);
`else
    check("pa_out", {32'd0, pa_out}, {32'd0, pa_in});
    check("pb_out", {32'd0, pb_out}, {32'd0, pb_in});
    check("raw_hazard", {63'd0, raw_hazard}, {63'd0, ma[32] | mb[32]});
`endif
    if (rst) begin
      pend.delete();
      exp_q.delete();
    end else begin
      if (exp_ld) void'(pend.pop_front());
      if (v && exp_ready && rd != 5'd0) begin
        pend.push_back({rd, d});
        exp_q.push_back({rd, d});
      end
    end
  endtask

  task automatic idle(input logic stall);
    step(1'b0, 5'd0, 32'd0, stall, 1'b0, 5'd0, 5'd0);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf_model[i] = 32'd0;
    reset = 1'b1; wb_valid = 1'b0; wb_rd = '0; wb_data = '0; rf_stall = 1'b0;
    rd_a_addr = '0; rd_b_addr = '0; pa_in = '0; pb_in = '0;
    repeat (2) @(posedge clk);
    mon_en = 1'b1;
    step(1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 5'd0, 5'd0);
    idle(1'b0);  // post-reset state checked by the step itself

    // Single write into an empty queue
    step(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 1'b0, 5'd5, 5'd0);
    idle(1'b0);
    check("single_addr", {59'd0, rf_addr}, 64'd5);
    check("single_data", {32'd0, rf_data}, 64'hDEADBEEF);
    idle(1'b0);

    // Fill under stall, then release
    for (int r = 1; r <= 4; r++) step(1'b1, 5'(r), 32'h100 + 32'(r), 1'b1, 1'b0, 5'(r), 5'd0);
    idle(1'b1);
    check("fill_not_ready", {63'd0, wb_ready}, 64'd0);
    for (int r = 1; r <= 4; r++) begin
      idle(1'b0);
      check("fill_drain_order", {59'd0, rf_addr}, 64'(r));
    end
    idle(1'b0);

    // r0 write is handshaken and dropped
    step(1'b1, 5'd0, 32'h12345678, 1'b0, 1'b0, 5'd0, 5'd0);
    check("r0_ready", {63'd0, wb_ready}, 64'd1);
    idle(1'b0);
    idle(1'b0);

    // Same-register ordering and forwarding
    step(1'b1, 5'd7, 32'h1, 1'b1, 1'b0, 5'd0, 5'd0);
    step(1'b1, 5'd7, 32'h2, 1'b1, 1'b0, 5'd0, 5'd0);
    step(1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 5'd7, 5'd0);
`ifdef RF_BYPASS_EN
    check("fwd_r7", {32'd0, pa_out}, 64'h2);
`else
    check("hazard_r7", {63'd0, raw_hazard}, 64'd1);
`endif
    repeat (3) idle(1'b0);
    check("r7_final", {32'd0, rf_model[7]}, 64'h2);

    // Full with a simultaneous pop: no push that cycle, accepted on the next
    for (int r = 1; r <= 4; r++) step(1'b1, 5'(r + 8), 32'h200 + 32'(r), 1'b1, 1'b0, 5'd0, 5'd0);
    step(1'b1, 5'd20, 32'hAAAA0000, 1'b0, 1'b0, 5'd20, 5'd0);
    step(1'b1, 5'd21, 32'hBBBB0000, 1'b0, 1'b0, 5'd21, 5'd20);
    check("full_pop_then_ready", {63'd0, wb_ready}, 64'd1);
    repeat (6) idle(1'b0);

    // Reset mid-drain
    for (int r = 1; r <= 3; r++) step(1'b1, 5'(r + 12), 32'h300 + 32'(r), 1'b1, 1'b0, 5'd0, 5'd0);
    step(1'b1, 5'd30, 32'h0BAD0BAD, 1'b0, 1'b1, 5'd13, 5'd14);
    step(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd13, 5'd14);
    check("reset_rf_ld", {63'd0, rf_ld}, 64'd0);
    check("reset_pa_out", {32'd0, pa_out}, {32'd0, pa_in});

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      step($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), $urandom,
           $urandom_range(0, 3) == 0, $urandom_range(0, 199) == 0,
           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    end
    repeat (DEPTH + 2) idle(1'b0);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
